// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-port register file.
// byte_merge works on a wide fixed container so any DATA_W/BYTE_W combination can share it.
package reg_file_pkg;

  localparam int BYTE_W_DEF = 8;
  localparam int MERGE_W    = 256;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  typedef enum logic [0:0] {
    CLEAR = ST_CLEAR,
    READY = ST_READY
  } state_e;

  // Bit b takes new_v when the strobe of its lane (b / lane_w) is set.
  function automatic logic [MERGE_W-1:0] byte_merge(
    input logic [MERGE_W-1:0] old_v,
    input logic [MERGE_W-1:0] new_v,
    input logic [MERGE_W-1:0] strb,
    input int                 lane_w
  );
    logic [MERGE_W-1:0] res;
    res = old_v;
    for (int b = 0; b < MERGE_W; b++) begin
      if (strb[b / lane_w]) res[b] = new_v[b];
    end
    return res;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Request/response bundle of the multi-port register file.
interface reg_file_mp_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam int STRB_W = DATA_W / BYTE_W;

  logic                     busy;
  logic                     drop_err;
  logic                     wr_en;
  logic [ADDR_W-1:0]        wr_addr;
  logic [DATA_W-1:0]        wr_data;
  logic [STRB_W-1:0]        wr_strb;
  logic [NUM_RD-1:0]        rd_en;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_valid;

  modport master (
    output wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    input  busy, drop_err, rd_data, rd_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, wr_strb, rd_en, rd_addr,
    output busy, drop_err, rd_data, rd_valid
  );

endinterface

// File: rtl/reg_file_clear_seq.sv
// Post-reset clear sequencer: sweeps a zero write over every entry, then reports ready.
module reg_file_clear_seq
  import reg_file_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     busy,
  output logic                     clr_we,
  output logic [$clog2(DEPTH)-1:0] clr_addr
);
  localparam int ADDR_W = $clog2(DEPTH);

  state_e            state;
  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == ADDR_W'(DEPTH - 1)) state <= READY;
    end
  end

  assign busy     = (state == CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports, one byte-strobed write port,
// same-cycle write-to-read forwarding and a hardware clear sweep after reset.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BYTE_W = BYTE_W_DEF,
  parameter int DEPTH  = 16,
  parameter int NUM_RD = 2
) (
  input  logic          clk,
  input  logic          rst,
  reg_file_mp_if.slave  bus
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              accept;
  logic              wr_acc;
  logic              drop_q;
  logic [DATA_W-1:0] wr_merged;
  logic [DATA_W-1:0] mem [DEPTH];

  reg_file_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
    .clk      (clk),
    .rst      (rst),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Requests are only honoured once the sweep is finished and reset is low.
  assign accept = !busy && !rst;
  assign wr_acc = accept && bus.wr_en;

  always_comb begin
    wr_merged = DATA_W'(byte_merge(MERGE_W'(mem[bus.wr_addr]), MERGE_W'(bus.wr_data),
                                   MERGE_W'(bus.wr_strb), BYTE_W));
  end

  always_ff @(posedge clk) begin
    if (clr_we)      mem[clr_addr]    <= '0;
    else if (wr_acc) mem[bus.wr_addr] <= wr_merged;
  end

  always_ff @(posedge clk) begin
    if (rst)                                      drop_q <= 1'b0;
    else if (busy && (bus.wr_en || |bus.rd_en))   drop_q <= 1'b1;
  end

  assign bus.busy     = busy;
  assign bus.drop_err = drop_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] data_p0;
    logic [DATA_W-1:0] rd_data_p1;
    logic              vld_p1;

    assign addr_p0 = bus.rd_addr[p*ADDR_W +: ADDR_W];
    assign data_p0 = (wr_acc && (bus.wr_addr == addr_p0)) ? wr_merged : mem[addr_p0];

    // p0 -> p1: registered read output
    always_ff @(posedge clk) begin
      if (rst) begin
        rd_data_p1 <= '0;
        vld_p1     <= 1'b0;
      end else begin
        vld_p1 <= accept && bus.rd_en[p];
        if (accept && bus.rd_en[p]) rd_data_p1 <= data_p0;
      end
    end

    assign bus.rd_data[p*DATA_W +: DATA_W] = rd_data_p1;
    assign bus.rd_valid[p]                 = vld_p1;
  end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: directed scenarios plus random traffic against an array model.
module tb_reg_file_mp;
  import reg_file_pkg::*;

  localparam int DW = 32;
  localparam int DEP = 16;

  typedef struct packed {
    logic       busy;
    logic       drop;
    logic       rst;
    logic [1:0] vld;
  } ctrl_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  reg_file_mp_if #(.DATA_W(DW), .BYTE_W(8), .DEPTH(DEP), .NUM_RD(2)) bus ();

  reg_file_mp #(.DATA_W(DW), .BYTE_W(8), .DEPTH(DEP), .NUM_RD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  ctrl_t       cq[$];
  logic [31:0] dq0[$];
  logic [31:0] dq1[$];

  logic [31:0] model [DEP];
  int          sweep_left = 0;
  logic        drop_m = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle of stimulus; the model decides what the DUT must show after the next edge.
  task automatic cyc(input logic r, input logic we, input logic [3:0] wa, input logic [31:0] wd,
                     input logic [3:0] ws, input logic [1:0] re, input logic [3:0] ra0,
                     input logic [3:0] ra1);
    ctrl_t c;
    rst         = r;
    bus.wr_en   = we;
    bus.wr_addr = wa;
    bus.wr_data = wd;
    bus.wr_strb = ws;
    bus.rd_en   = re;
    bus.rd_addr = {ra1, ra0};
    c = '0;
    if (r) begin
      sweep_left = DEP;
      drop_m     = 1'b0;
      c.rst      = 1'b1;
    end else if (sweep_left > 0) begin
      if (we || re != 2'b00) drop_m = 1'b1;
      sweep_left--;
      if (sweep_left == 0) for (int i = 0; i < DEP; i++) model[i] = 32'h0;
    end else begin
      if (we) for (int l = 0; l < 4; l++) if (ws[l]) model[wa][8*l +: 8] = wd[8*l +: 8];
      if (re[0]) dq0.push_back(model[ra0]);
      if (re[1]) dq1.push_back(model[ra1]);
      c.vld = re;
    end
    c.busy = r || (sweep_left > 0);
    c.drop = drop_m;
    cq.push_back(c);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc(1'b0, 1'b1, a, d, s, 2'b00, 4'h0, 4'h0);
  endtask

  task automatic rd(input logic [1:0] re, input logic [3:0] a0, input logic [3:0] a1);
    cyc(1'b0, 1'b0, 4'h0, 32'h0, 4'h0, re, a0, a1);
  endtask

  // Monitor: compares whatever the DUT presents after each edge against the queued expectation.
  initial begin : monitor
    logic [31:0] last0, last1, e;
    ctrl_t c;
    last0 = 32'h0;
    last1 = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      if (cq.size() != 0) begin
        c = cq.pop_front();
        if (c.rst) begin
          last0 = 32'h0;
          last1 = 32'h0;
        end
        check("busy", {31'h0, bus.busy}, {31'h0, c.busy});
        check("drop_err", {31'h0, bus.drop_err}, {31'h0, c.drop});
        check("rd_valid", {30'h0, bus.rd_valid}, {30'h0, c.vld});
        if (c.vld[0]) begin
          e = (dq0.size() != 0) ? dq0.pop_front() : 32'hxxxxxxxx;
          last0 = e;
        end
        if (c.vld[1]) begin
          e = (dq1.size() != 0) ? dq1.pop_front() : 32'hxxxxxxxx;
          last1 = e;
        end
        check("rd_data0", bus.rd_data[31:0], last0);
        check("rd_data1", bus.rd_data[63:32], last1);
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    logic [3:0] a;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.wr_strb = '0;
    bus.rd_en = '0;   bus.rd_addr = '0;
    for (int i = 0; i < DEP; i++) model[i] = 32'h0;
    @(negedge clk);

    // Reset, sweep, then read back every entry.
    repeat (3) cyc(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    idle(DEP);
    for (int i = 0; i < DEP; i++) rd(2'b11, 4'(i), 4'(DEP - 1 - i));

    // Byte-strobed merge on addr 5.
    wr(4'd5, 32'hDEADBEEF, 4'hF);
    wr(4'd5, 32'h11223344, 4'b0101);
    rd(2'b01, 4'd5, 4'd0);
    rd(2'b10, 4'd0, 4'd5);

    // Same-cycle write with forwarding on port 0 only.
    cyc(1'b0, 1'b1, 4'd3, 32'hCAFEF00D, 4'hF, 2'b11, 4'd3, 4'd4);
    idle(2);
    rd(2'b11, 4'd3, 4'd3);

    // Both ports on one address.
    wr(4'd15, 32'hA5A5A5A5, 4'hF);
    rd(2'b11, 4'd15, 4'd15);
    wr(4'd2, 32'h12345678, 4'hF);
    cyc(1'b0, 1'b1, 4'd7, 32'h0BADF00D, 4'b0000, 2'b01, 4'd7, 4'd0);

    // Request during sweep sets sticky drop_err; addr 2 is cleared afterwards.
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    idle(5);
    wr(4'd2, 32'hFFFFFFFF, 4'hF);
    idle(DEP - 6);
    idle(3);
    rd(2'b11, 4'd2, 4'd15);

    // Reset in the middle of a sweep restarts it; drop_err stays clear.
    wr(4'd9, 32'h87654321, 4'hF);
    rd(2'b01, 4'd9, 4'd0);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    idle(9);
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    idle(DEP);
    rd(2'b11, 4'd9, 4'd2);

    // Random traffic with frequent address collisions.
    for (int n = 0; n < 400; n++) begin
      a = 4'($urandom_range(0, 3)) + 4'd6;
      cyc(1'b0, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), 2'($urandom),
          4'($urandom_range(0, 3)) + 4'd6, 4'($urandom));
    end

    // Random mid-traffic reset and sweep with requests arriving while busy.
    cyc(1'b1, 1'b0, 4'h0, 32'h0, 4'h0, 2'b00, 4'h0, 4'h0);
    for (int n = 0; n < DEP + 40; n++)
      cyc(1'b0, 1'($urandom_range(0, 1)), 4'($urandom), $urandom, 4'($urandom), 2'($urandom),
          4'($urandom), 4'($urandom));
    idle(3);

    repeat (3) @(negedge clk);
    total++;
    if (cq.size() != 0 || dq0.size() != 0 || dq1.size() != 0) begin
      bad++;
      $display("FAIL drain: ctrl=%0d rd0=%0d rd1=%0d entries left, expected 0",
               cq.size(), dq0.size(), dq1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file: NUM_RD independent read ports, one byte-strobed write port, write-to-read forwarding, and a hardware clear sequencer that zeroes every entry after reset. Read and write may occur in the same cycle. It serves as the general-purpose register storage for the datapath and is configurable in width, depth and read-port count.

## Interface
- DATA_W, 32, entry width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, byte-lane width for write strobes
- DEPTH, 16, number of entries; power of two, ≥2
- ADDR_W, $clog2(DEPTH), address width (derived)
- NUM_RD, 2, number of read ports, 1..4
- clk  in  1  clock; all logic is rising-edge
- rst  in  1  reset, synchronous, active-high
- busy  out  1  high while reset or clear sweep is in progress
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- wr_strb  in  DATA_W/BYTE_W  per-lane write enable
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port p at [p*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed read data, registered
- rd_valid  out  NUM_RD  per-port, 1-cycle pulse marking rd_data valid
- drop_err  out  1  sticky; set when a request arrives while busy

## Operation
- FSM states: CLEAR, READY. rst forces CLEAR, clear pointer to 0, busy=1.
- CLEAR: each cycle with rst low, write all-zero to entry[ptr] and increment ptr; on ptr==DEPTH-1, go to READY next cycle. The sweep takes exactly DEPTH cycles after rst deasserts.
- READY: busy=0. Requests are accepted every cycle with no back-pressure.
- Write: for each lane i with wr_strb[i]=1, entry[wr_addr] lane i is updated with wr_data lane i. Other lanes are unchanged. wr_strb=0 with wr_en=1 is a no-op.
- Read, port p: when rd_en[p]=1, the next cycle has rd_data[p] = entry[rd_addr[p]] and rd_valid[p]=1. When rd_en[p]=0, rd_valid[p]=0 and rd_data[p] holds its previous value.
- Read and write to the same address in the same cycle: the read returns the post-write merged value (forwarding), byte-accurate per strobe.
- Several ports may read the same address; every port returns identical data.
- While busy, wr_en and rd_en are ignored: no storage change and no rd_valid. Any asserted request in a non-reset busy cycle sets drop_err. drop_err clears only on rst.
- Reset values: rd_data=0, rd_valid=0, busy=1, drop_err=0. Storage is undefined until the sweep completes.
- rst asserted mid-sweep: the sweep restarts from entry 0. rst asserted in READY: outputs return to reset values next edge and a full sweep follows.

## Timing
- Read latency: 1 cycle, request edge to rd_data/rd_valid.
- Write visibility: a read issued in the same cycle as the write sees the new data (forwarded). Later reads see it from storage.
- busy deasserts DEPTH cycles after the first edge with rst low. The first accepted request is on the edge where busy is observed 0.
- Throughput: one write plus NUM_RD reads per cycle.

## Structure
- Package reg_file_pkg: state enum {CLEAR, READY}; default BYTE_W; function byte_merge(old, new, strb).
- Sub-module reg_file_clear_seq: holds the FSM and clear pointer, and outputs busy, clr_we and clr_addr. The top level muxes the clear write over the user write port.
- Storage is a flop array (no RAM macro); the read mux and forwarding are per port in a generate loop.

## Test plan
- Reset then idle: busy high for exactly 16 cycles after rst falls. Then reading all 16 addresses returns 0x00000000 with rd_valid 1 cycle after each request.
- Write 0xDEADBEEF to addr 5 with strb 4'hF, then write 0x11223344 with strb 4'b0101: a read of addr 5 returns 0xDE22BE44.
- Same cycle: write 0xCAFEF00D to addr 3 with port 0 reading addr 3 and port 1 reading addr 4 (holding 0): the next cycle gives port 0 0xCAFEF00D and port 1 0x00000000, both valid.
- wr_en to addr 2 during the sweep at cycle 5: drop_err=1 and stays 1. After the sweep, addr 2 reads 0.
- Assert rst at sweep cycle 9 and release: busy stays high a further 16 cycles. drop_err is 0 and rd_data is 0.
- Both ports read addr 15 after writing 0xA5A5A5A5: both return the same value in the same cycle, and rd_valid=2'b11.
